// File: rtl/alu_seq.sv
// Handshaked sequential ALU: seven single-cycle ops plus an iterative shift-add unsigned multiply.
// Optional carry/no-borrow flag port C is enabled by defining ALU_CARRY_EN.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             N,
`ifdef ALU_CARRY_EN
    output logic             C,
`endif
    output logic             V
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_out;
    logic                 r_z;
    logic                 r_n;
    logic                 r_v;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_a;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;

    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [WIDTH-1:0]     w_res;
    logic                 w_v;
    logic [WIDTH:0]       w_hi_sum;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_add = {1'b0, Ain} + {1'b0, Bin};
    assign w_sub = {1'b0, Ain} - {1'b0, Bin};

    // Single-cycle result and overflow flag, evaluated straight from the presented operands
    always_comb begin
        w_res = {WIDTH{1'b0}};
        w_v   = 1'b0;
        case (ALUop)
            3'b000: begin
                w_res = w_add[MSB:0];
                w_v   = (Ain[MSB] == Bin[MSB]) && (w_add[MSB] != Ain[MSB]);
            end
            3'b001: begin
                w_res = w_sub[MSB:0];
                w_v   = (Ain[MSB] != Bin[MSB]) && (w_sub[MSB] != Ain[MSB]);
            end
            3'b010:  w_res = Ain & Bin;
            3'b011:  w_res = ~Bin;
            3'b100:  w_res = Ain | Bin;
            3'b101:  w_res = Ain ^ Bin;
            3'b110:  w_res = Ain << Bin[SHW-1:0];
            default: w_res = {WIDTH{1'b0}};
        endcase
    end

`ifdef ALU_CARRY_EN
    logic r_c;
    logic w_c;

    // Carry-out for ADD, no-borrow for SUB, zero otherwise
    always_comb begin
        w_c = 1'b0;
        case (ALUop)
            3'b000:  w_c = w_add[WIDTH];
            3'b001:  w_c = ~w_sub[WIDTH];
            default: w_c = 1'b0;
        endcase
    end

    assign C = r_c;
`else
    logic w_unused_carry;
    assign w_unused_carry = w_add[WIDTH] ^ w_sub[WIDTH];
`endif

    // Multiplier step: low half of r_acc holds the remaining multiplier bits, high half the partial product
    assign w_hi_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_acc_next = {w_hi_sum, r_acc[WIDTH-1:1]};

    // Control FSM with registered result, flags and out_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out       <= {WIDTH{1'b0}};
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            r_out_valid <= 1'b0;
            r_a         <= {WIDTH{1'b0}};
            r_acc       <= {(2*WIDTH){1'b0}};
            r_cnt       <= {CW{1'b0}};
`ifdef ALU_CARRY_EN
            r_c         <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (ALUop == 3'b111) begin
                            r_a     <= Ain;
                            r_acc   <= {{WIDTH{1'b0}}, Bin};
                            r_cnt   <= {CW{1'b0}};
                            r_state <= MUL;
                        end else begin
                            r_out       <= w_res;
                            r_z         <= (w_res == {WIDTH{1'b0}});
                            r_n         <= w_res[MSB];
                            r_v         <= w_v;
`ifdef ALU_CARRY_EN
                            r_c         <= w_c;
`endif
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    // Last of the WIDTH iterations publishes the product directly
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_out       <= w_acc_next[WIDTH-1:0];
                        r_z         <= (w_acc_next[WIDTH-1:0] == {WIDTH{1'b0}});
                        r_n         <= w_acc_next[MSB];
                        r_v         <= |w_acc_next[2*WIDTH-1:WIDTH];
`ifdef ALU_CARRY_EN
                        r_c         <= 1'b0;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign Z         = r_z;
    assign N         = r_n;
    assign V         = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16; checks C as well when ALU_CARRY_EN is defined.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic [2:0]  ALUop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        Z;
    logic        N;
    logic        V;
`ifdef ALU_CARRY_EN
    logic        C;
`endif

    int n_chk = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .Z         (Z),
        .N         (N),
`ifdef ALU_CARRY_EN
        .C         (C),
`endif
        .V         (V)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for the result, check it, then consume it.
    // exp_lat counts edges after the acceptance edge until out_valid is seen high.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_out,
                          input logic exp_v, input logic exp_c, input int exp_lat);
        int   cnt;
        logic busy_ready;
        Ain = a; Bin = b; ALUop = op; in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        busy_ready = 1'b0;
        while (!out_valid && cnt < 50) begin
            if (in_ready) busy_ready = 1'b1;
            @(posedge clk); #1; cnt++;
        end
        check({tag, "/lat"}, cnt, exp_lat);
        check({tag, "/busy_ready"}, {31'd0, busy_ready}, 32'd0);
        check({tag, "/out"}, {16'd0, out}, {16'd0, exp_out});
        check({tag, "/Z"}, {31'd0, Z}, {31'd0, (exp_out == 16'h0000)});
        check({tag, "/N"}, {31'd0, N}, {31'd0, exp_out[15]});
        check({tag, "/V"}, {31'd0, V}, {31'd0, exp_v});
`ifdef ALU_CARRY_EN
        check({tag, "/C"}, {31'd0, C}, {31'd0, exp_c});
`else
        if (exp_c === 1'bx) $display("note: %s has undefined carry expectation", tag);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "/drain_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "/drain_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "/hold_out"}, {16'd0, out}, {16'd0, exp_out});
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Ain = 16'h0000; Bin = 16'h0000; ALUop = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("rst/valid", {31'd0, out_valid}, 32'd0);
        check("rst/ready", {31'd0, in_ready}, 32'd1);
        check("rst/out", {16'd0, out}, 32'd0);
        check("rst/flags", {29'd0, Z, N, V}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        //      tag      op      A         B         out       V     C     lat
        run_op("add_ov", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 0);
        run_op("sub_eq", 3'b001, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 0);
        run_op("sub_ov", 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 0);
        // Shift amount is Bin[3:0] = 4, so 3 << 4
        run_op("shl4",   3'b110, 16'h0003, 16'hFFF4, 16'h0030, 1'b0, 1'b0, 0);
        run_op("shl1",   3'b110, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b0, 0);
        run_op("shl15",  3'b110, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 0);
        run_op("and",    3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 0);
        run_op("or",     3'b100, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0, 0);
        run_op("not",    3'b011, 16'h1234, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 0);
        run_op("mul_hi", 3'b111, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 16);
        run_op("mul_lo", 3'b111, 16'h00FF, 16'h0003, 16'h02FD, 1'b0, 1'b0, 16);
        run_op("mul_mx", 3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16);
`ifdef ALU_CARRY_EN
        run_op("add_c",  3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 0);
        run_op("sub_nb", 3'b001, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 0);
`endif

        // Backpressure on an XOR result with new operands held at the input
        Ain = 16'hF0F0; Bin = 16'h0FF0; ALUop = 3'b101; in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp/valid", {31'd0, out_valid}, 32'd1);
        Ain = 16'h0001; Bin = 16'h0001; ALUop = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp/out", {16'd0, out}, 32'h0000FF00);
            check("bp/flags", {29'd0, Z, N, V}, 32'd2);
            check("bp/stall", {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp/release", {30'd0, out_valid, in_ready}, 32'd1);
        check("bp/out_hold", {16'd0, out}, 32'h0000FF00);
        @(posedge clk); #1;
        check("bp/no_accept", {30'd0, out_valid, in_ready}, 32'd1);

        // Reset in the middle of a multiply; previous result was nonzero
        run_op("pre_rst", 3'b111, 16'h00FF, 16'h0003, 16'h02FD, 1'b0, 1'b0, 16);
        Ain = 16'h0100; Bin = 16'h0100; ALUop = 3'b111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mrst/busy", {31'd0, in_ready}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst/valid", {31'd0, out_valid}, 32'd0);
        check("mrst/ready", {31'd0, in_ready}, 32'd1);
        check("mrst/out", {16'd0, out}, 32'd0);
        check("mrst/flags", {29'd0, Z, N, V}, 32'd0);
        run_op("post_rst", 3'b000, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
